decode_issue: RTL and testbench

- Decode/issue stage of the in-order RV32I pipeline; the producer side of the execute-stage operand interface.
- Accepts fetched instruction+PC via valid/ready, decodes ALU-class ops, reads an internal 32x32 register file, tracks pending writes in a scoreboard.
- Registers opsel1/opsel2/alu_func/rs1_value/rs2_value/imm/pc_o into a one-entry output stage for execute.
- Write-back port from the end of the pipe updates the register file and clears scoreboard bits.

---
 rtl/decode_issue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_decode_issue.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage of the in-order RV32I pipeline.
// Decodes ALU-class ops (OP, OP-IMM, LUI, AUIPC), reads a 32x32 register file,
// tracks pending destination writes in a scoreboard and hands operands to
// execute through a one-entry registered output stage.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   if_valid/if_ready      fetch handshake (if_ready is combinational)
//   instr, pc_i            instruction word and its PC
//   ex_valid/ex_ready      execute handshake for the held op
//   opsel1, opsel2         operand selects (1: 0=rs1,1=pc,2=zero; 2: 0=rs2,1=imm,2=4)
//   alu_func               0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
//   rs1_value, rs2_value   register operands (0 when the source is unused)
//   imm, pc_o              sign-extended immediate, PC of issued op
//   rd, rd_we, illegal     destination, write enable, unsupported-op flag
//   wb_we, wb_rd, wb_data  write-back port from the end of the pipe
//   flush                  squash the held op and all pending scoreboard bits
//
// Build option: define WB_BYPASS_EN to forward same-cycle write-back data into
// the operands (and drop the matching scoreboard stall).
module decode_issue #(
    parameter int unsigned WORD     = 32,
    parameter int unsigned ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [31:0]         instr,
    input  logic [ADDR_LEN-1:0] pc_i,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [1:0]          opsel1,
    output logic [1:0]          opsel2,
    output logic [3:0]          alu_func,
    output logic [WORD-1:0]     rs1_value,
    output logic [WORD-1:0]     rs2_value,
    output logic [WORD-1:0]     imm,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [4:0]          rd,
    output logic                rd_we,
    output logic                illegal,
    input  logic                wb_we,
    input  logic [4:0]          wb_rd,
    input  logic [WORD-1:0]     wb_data,
    input  logic                flush
);

    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SEL1_RS   = 2'd0;
    localparam logic [1:0] SEL1_PC   = 2'd1;
    localparam logic [1:0] SEL1_ZERO = 2'd2;
    localparam logic [1:0] SEL2_RS   = 2'd0;
    localparam logic [1:0] SEL2_IMM  = 2'd1;

    // funct3 -> ALU op; alt selects SUB/SRA variants
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [WORD-1:0]     r_rf [NREGS];
    logic [NREGS-1:0]    r_sb;
    logic                r_ex_valid;
    logic [1:0]          r_opsel1;
    logic [1:0]          r_opsel2;
    logic [3:0]          r_alu_func;
    logic [WORD-1:0]     r_rs1_value;
    logic [WORD-1:0]     r_rs2_value;
    logic [WORD-1:0]     r_imm;
    logic [ADDR_LEN-1:0] r_pc;
    logic [4:0]          r_rd;
    logic                r_rd_we;
    logic                r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [WORD-1:0] w_imm_i;
    logic [WORD-1:0] w_imm_u;
    logic [1:0]      w_op1;
    logic [1:0]      w_op2;
    logic [3:0]      w_func;
    logic [WORD-1:0] w_imm;
    logic            w_use1;
    logic            w_use2;
    logic            w_illegal;
    logic [4:0]      w_rd;
    logic            w_rd_we;
    logic            w_byp1;
    logic            w_byp2;
    logic [WORD-1:0] w_rs1_val;
    logic [WORD-1:0] w_rs2_val;
    logic            w_hz1;
    logic            w_hz2;
    logic            w_stall;
    logic            w_load;
    logic            w_accept;
    logic            w_handoff;
    logic [NREGS-1:0] w_sb_next;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_imm_i  = WORD'($signed(instr[31:20]));
    assign w_imm_u  = WORD'($signed({instr[31:12], 12'b0}));

    // Instruction decode; unsupported opcodes become ADD x0,x0,0 with no sources
    always_comb begin
        w_op1     = SEL1_RS;
        w_op2     = SEL2_IMM;
        w_func    = ALU_ADD;
        w_imm     = '0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_illegal = 1'b0;
        w_rd      = instr[11:7];
        case (w_opcode)
            OPC_OP: begin
                w_op2  = SEL2_RS;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_func = alu_sel(w_f3, instr[30]);
            end
            OPC_OPIMM: begin
                w_use1 = 1'b1;
                w_imm  = w_imm_i;
                // bit 30 is an immediate bit except for the SRLI/SRAI pair
                w_func = alu_sel(w_f3, (w_f3 == 3'd5) && instr[30]);
            end
            OPC_LUI: begin
                w_op1 = SEL1_ZERO;
                w_imm = w_imm_u;
            end
            OPC_AUIPC: begin
                w_op1 = SEL1_PC;
                w_imm = w_imm_u;
            end
            default: begin
                w_illegal = 1'b1;
                w_rd      = 5'd0;
            end
        endcase
    end

    assign w_rd_we = !w_illegal && (w_rd != 5'd0);

`ifdef WB_BYPASS_EN
    assign w_byp1 = wb_we && (wb_rd == w_rs1) && (w_rs1 != 5'd0);
    assign w_byp2 = wb_we && (wb_rd == w_rs2) && (w_rs2 != 5'd0);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Operand read; unused sources and x0 read as zero
    assign w_rs1_val = (!w_use1 || (w_rs1 == 5'd0)) ? '0 : (w_byp1 ? wb_data : r_rf[w_rs1]);
    assign w_rs2_val = (!w_use2 || (w_rs2 == 5'd0)) ? '0 : (w_byp2 ? wb_data : r_rf[w_rs2]);

    // Hazard: pending scoreboard write, or the op currently held for execute writes it
    assign w_hz1 = (r_sb[w_rs1] && !w_byp1) || (r_ex_valid && r_rd_we && (r_rd == w_rs1));
    assign w_hz2 = (r_sb[w_rs2] && !w_byp2) || (r_ex_valid && r_rd_we && (r_rd == w_rs2));
    assign w_stall = (w_use1 && w_hz1) || (w_use2 && w_hz2);

    assign w_load    = !r_ex_valid || ex_ready;
    assign if_ready  = !w_stall && w_load && !flush;
    assign w_accept  = if_valid && if_ready;
    assign w_handoff = r_ex_valid && ex_ready && r_rd_we;

    // Scoreboard update: clear on write-back, then set on handoff so set wins
    always_comb begin
        w_sb_next = r_sb;
        if (wb_we) begin
            w_sb_next[wb_rd] = 1'b0;
        end
        if (w_handoff) begin
            w_sb_next[r_rd] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    // Register file, intentionally not reset
    always_ff @(posedge clk) begin
        if (wb_we && (wb_rd != 5'd0)) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // Output stage and scoreboard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb        <= '0;
            r_ex_valid  <= 1'b0;
            r_opsel1    <= '0;
            r_opsel2    <= '0;
            r_alu_func  <= '0;
            r_rs1_value <= '0;
            r_rs2_value <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_sb       <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            r_sb <= w_sb_next;
            if (w_load) begin
                r_ex_valid <= w_accept;
                if (w_accept) begin
                    r_opsel1    <= w_op1;
                    r_opsel2    <= w_op2;
                    r_alu_func  <= w_func;
                    r_rs1_value <= w_rs1_val;
                    r_rs2_value <= w_rs2_val;
                    r_imm       <= w_imm;
                    r_pc        <= pc_i;
                    r_rd        <= w_rd;
                    r_rd_we     <= w_rd_we;
                    r_illegal   <= w_illegal;
                end
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign opsel1    = r_opsel1;
    assign opsel2    = r_opsel2;
    assign alu_func  = r_alu_func;
    assign rs1_value = r_rs1_value;
    assign rs2_value = r_rs2_value;
    assign imm       = r_imm;
    assign pc_o      = r_pc;
    assign rd        = r_rd;
    assign rd_we     = r_rd_we;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and randomized checks of decode_issue against a
// behavioural model (architectural register array, pending-write set, held op).
`timescale 1ns/1ps
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instr;
    logic [31:0] pc_i;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  opsel1;
    logic [1:0]  opsel2;
    logic [3:0]  alu_func;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
    logic [31:0] pc_o;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;

    decode_issue #(.WORD(32), .ADDR_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_ready(if_ready),
        .instr(instr), .pc_i(pc_i),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .opsel1(opsel1), .opsel2(opsel2), .alu_func(alu_func),
        .rs1_value(rs1_value), .rs2_value(rs2_value), .imm(imm),
        .pc_o(pc_o), .rd(rd), .rd_we(rd_we), .illegal(illegal),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op1;
        logic [1:0]  op2;
        logic [3:0]  func;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } out_t;

    typedef struct {
        out_t       o;
        logic       use1;
        logic       use2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

    // model state
    logic [31:0] m_rf [32];
    logic [31:0] m_sb;
    logic        m_valid;
    out_t        m_out;
    logic [4:0]  q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic out_t zero_out();
        out_t o;
        o.op1 = 2'd0; o.op2 = 2'd0; o.func = 4'd0; o.v1 = 32'd0; o.v2 = 32'd0;
        o.imm = 32'd0; o.pc = 32'd0; o.rd = 5'd0; o.we = 1'b0; o.ill = 1'b0;
        return o;
    endfunction

    // ALU code from the architectural funct3 meaning
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        int unsigned t [8];
        t = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return 4'(t[f3]);
    endfunction

    function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        logic [2:0] f3;
        f3 = ins[14:12];
        d.o = zero_out();
        d.o.op2 = 2'd1;
        d.o.pc  = pc;
        d.use1 = 1'b0; d.use2 = 1'b0;
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        case (ins[6:0])
            7'h33: begin
                d.o.op2 = 2'd0; d.use1 = 1'b1; d.use2 = 1'b1;
                d.o.func = alu_of(f3, ins[30]); d.o.rd = ins[11:7];
            end
            7'h13: begin
                d.use1 = 1'b1; d.o.imm = {{20{ins[31]}}, ins[31:20]};
                d.o.func = alu_of(f3, (f3 == 3'd5) && ins[30]); d.o.rd = ins[11:7];
            end
            7'h37: begin
                d.o.op1 = 2'd2; d.o.imm = {ins[31:12], 12'h000}; d.o.rd = ins[11:7];
            end
            7'h17: begin
                d.o.op1 = 2'd1; d.o.imm = {ins[31:12], 12'h000}; d.o.rd = ins[11:7];
            end
            default: d.o.ill = 1'b1;
        endcase
        d.o.we = !d.o.ill && (d.o.rd != 5'd0);
        return d;
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] r, input logic wwe,
                                          input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wwe && wrd == r) return wd;
`endif
        return m_rf[r];
    endfunction

    function automatic logic hazard(input logic [4:0] r, input logic wwe, input logic [4:0] wrd);
        logic pend;
        pend = m_sb[r];
`ifdef WB_BYPASS_EN
        if (wwe && wrd == r && r != 5'd0) pend = 1'b0;
`endif
        return pend || (m_valid && m_out.we && m_out.rd == r);
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [4:0] d, a, b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [11:0] i12;
        logic [6:0] bad [7];
        bad = '{7'h6F, 7'h03, 7'h23, 7'h63, 7'h67, 7'h73, 7'h00};
        k = $urandom_range(0, 9);
        d = 5'($urandom_range(0, 7));
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        if (k <= 3) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom % 2 == 1)) ? 7'h20 : 7'h00;
            return {f7, b, a, f3, d, 7'h33};
        end else if (k <= 6) begin
            i12 = 12'($urandom);
            if (f3 == 3'd1) i12[11:5] = 7'h00;
            if (f3 == 3'd5) i12[11:5] = ($urandom % 2 == 1) ? 7'h20 : 7'h00;
            return {i12, a, f3, d, 7'h13};
        end else if (k == 7) begin
            return {20'($urandom), d, 7'h37};
        end else if (k == 8) begin
            return {20'($urandom), d, 7'h17};
        end
        return {25'($urandom), bad[$urandom_range(0, 6)]};
    endfunction

    task automatic compare_outputs();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid) begin
            chk("opsel1", 32'(opsel1), 32'(m_out.op1));
            chk("opsel2", 32'(opsel2), 32'(m_out.op2));
            chk("alu_func", 32'(alu_func), 32'(m_out.func));
            chk("rs1_value", rs1_value, m_out.v1);
            chk("rs2_value", rs2_value, m_out.v2);
            chk("imm", imm, m_out.imm);
            chk("pc_o", pc_o, m_out.pc);
            chk("rd", 32'(rd), 32'(m_out.rd));
            chk("rd_we", 32'(rd_we), 32'(m_out.we));
            chk("illegal", 32'(illegal), 32'(m_out.ill));
        end
    endtask

    // One clock: drive at negedge, check if_ready, advance model at posedge, check outputs
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic exr, input logic wwe, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic fl, output logic rdy);
        dec_t d;
        logic stall, exp_rdy, hand;
        @(negedge clk);
        if_valid = iv; instr = ins; pc_i = pc; ex_ready = exr;
        wb_we = wwe; wb_rd = wrd; wb_data = wd; flush = fl;
        #1;
        d = decode(ins, pc);
        if (d.use1) d.o.v1 = rdval(d.rs1, wwe, wrd, wd);
        if (d.use2) d.o.v2 = rdval(d.rs2, wwe, wrd, wd);
        stall = (d.use1 && hazard(d.rs1, wwe, wrd)) || (d.use2 && hazard(d.rs2, wwe, wrd));
        exp_rdy = !stall && (!m_valid || exr) && !fl;
        chk("if_ready", 32'(if_ready), 32'(exp_rdy));
        rdy = if_ready;
        hand = m_valid && exr && m_out.we;
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
            m_sb = 32'd0;
            q.delete();
        end else begin
            if (wwe && wrd != 5'd0) m_sb[wrd] = 1'b0;
            if (hand) begin
                m_sb[m_out.rd] = 1'b1;
                q.push_back(m_out.rd);
            end
            if (!m_valid || exr) begin
                m_valid = iv && exp_rdy;
                if (m_valid) m_out = d.o;
            end
        end
        if (wwe && wrd != 5'd0) m_rf[wrd] = wd;
        #1;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_opsel1"}, 32'(opsel1), 32'd0);
        chk({tag, "_opsel2"}, 32'(opsel2), 32'd0);
        chk({tag, "_alu_func"}, 32'(alu_func), 32'd0);
        chk({tag, "_rs1_value"}, rs1_value, 32'd0);
        chk({tag, "_rs2_value"}, rs2_value, 32'd0);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_pc_o"}, pc_o, 32'd0);
        chk({tag, "_rd"}, 32'(rd), 32'd0);
        chk({tag, "_rd_we"}, 32'(rd_we), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    localparam logic [31:0] I_ADDI1 = 32'h00500093;
    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_LUI5  = 32'h123452B7;
    localparam logic [31:0] I_SUB4  = 32'h40208233;
    localparam logic [31:0] I_AUIPC = 32'h00001317;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_ADDI7 = 32'h00100393;

    initial begin
        logic rs;
        logic iv, exr, wwe, fl;
        logic [31:0] ins, pc, wd;
        logic [4:0] wrd;

        reset = 1'b1;
        if_valid = 1'b0; instr = 32'd0; pc_i = 32'd0; ex_ready = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;
        m_sb = 32'd0; m_valid = 1'b0; m_out = zero_out();
        for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // give every register a known value
        for (int r = 1; r < 32; r++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'(r), $urandom, 1'b0, rs);
        end

        // addi x1,x0,5
        step(1'b1, I_ADDI1, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_opsel1", 32'(opsel1), 32'd0);
        chk("addi_opsel2", 32'(opsel2), 32'd1);
        chk("addi_func", 32'(alu_func), 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_rd_we", 32'(rd_we), 32'd1);
        chk("addi_pc", pc_o, 32'h100);

        // add x3,x1,x2 waits on x1
        step(1'b1, I_ADD3, 32'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("add_stall_held", 32'(rs), 32'd0);
        step(1'b1, I_ADD3, 32'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("add_stall_sb", 32'(rs), 32'd0);
        step(1'b1, I_ADD3, 32'h104, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0, rs);
`ifdef WB_BYPASS_EN
        chk("add_rdy_wb_cycle", 32'(rs), 32'd1);
`else
        chk("add_stall_wb_cycle", 32'(rs), 32'd0);
        step(1'b1, I_ADD3, 32'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("add_rdy_after_wb", 32'(rs), 32'd1);
`endif
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs1", rs1_value, 32'd5);
        chk("add_rd", 32'(rd), 32'd3);

        // lui held under back-pressure, sub waits for ex_ready
        step(1'b1, I_LUI5, 32'h108, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("lui_imm", imm, 32'h12345000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, I_SUB4, 32'h10c, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, rs);
            chk("sub_blocked", 32'(rs), 32'd0);
            chk("lui_hold_imm", imm, 32'h12345000);
            chk("lui_hold_opsel1", 32'(opsel1), 32'd2);
            chk("lui_hold_pc", pc_o, 32'h108);
        end
        step(1'b1, I_SUB4, 32'h10c, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("sub_accept", 32'(rs), 32'd1);
        chk("sub_func", 32'(alu_func), 32'd1);
        chk("sub_rd", 32'(rd), 32'd4);

        // auipc and an unsupported jal
        step(1'b1, I_AUIPC, 32'h200, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("auipc_opsel1", 32'(opsel1), 32'd1);
        chk("auipc_imm", imm, 32'h1000);
        chk("auipc_pc", pc_o, 32'h200);
        step(1'b1, I_JAL, 32'h204, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("jal_no_stall", 32'(rs), 32'd1);
        chk("jal_illegal", 32'(illegal), 32'd1);
        chk("jal_rd_we", 32'(rd_we), 32'd0);

        // flush with x1 pending and an op held
        step(1'b1, I_ADDI1, 32'h300, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        step(1'b1, I_ADDI7, 32'h304, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("addi7_accept", 32'(rs), 32'd1);
        step(1'b1, I_ADD3, 32'h308, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rs);
        chk("flush_rdy", 32'(rs), 32'd0);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        step(1'b1, I_ADD3, 32'h308, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, rs);
        chk("post_flush_rdy", 32'(rs), 32'd1);
        chk("post_flush_rd", 32'(rd), 32'd3);

        // asynchronous reset while an op is held
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        m_valid = 1'b0; m_sb = 32'd0; m_out = zero_out(); q.delete();
        @(posedge clk);
        @(negedge clk);
        if_valid = 1'b0; ex_ready = 1'b0; wb_we = 1'b0; flush = 1'b0;
        reset = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            iv  = ($urandom % 4) != 0;
            ins = rand_instr();
            pc  = $urandom & 32'hFFFF_FFFC;
            exr = ($urandom % 3) != 0;
            wwe = 1'b0; wrd = 5'd0; wd = $urandom;
            if (q.size() > 0 && ($urandom % 3) == 0) begin
                wwe = 1'b1;
                wrd = q.pop_front();
            end else if (($urandom % 40) == 0) begin
                wwe = 1'b1;
                wrd = 5'd0;
            end
            fl = ($urandom % 30) == 0;
            step(iv, ins, pc, exr, wwe, wrd, wd, fl, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
